// File: rtl/lab5_mcore_cache_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : lab5_mcore_cache_mem_arbiter                                      |
// | Merges the icache and dcache 16B memory request ports onto one shared     |
// | memory port with round-robin arbitration and one registered request slot. |
// | An in-order source-ID FIFO steers each memory response back to the cache  |
// | that issued the matching request.                                         |
// |                                                                          |
// | Ports:                                                                   |
// |   clk, rst_n (async, active-low)                                         |
// |   imemreq_*_i/o  : icache request  (msg 175b, val in, rdy out)           |
// |   dmemreq_*_i/o  : dcache request  (msg 175b, val in, rdy out)           |
// |   memreq_*       : memory request  (msg/val registered out, rdy in)      |
// |   memresp_*      : memory response (msg 145b, val in, rdy out)           |
// |   imemresp_*     : response to icache (msg/val out, rdy in)              |
// |   dmemresp_*     : response to dcache (msg/val out, rdy in)              |
// |                                                                          |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module lab5_mcore_cache_mem_arbiter #(
  parameter int P_MAX_OUTSTANDING = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [174:0] imemreq_msg_i,
  input  logic         imemreq_val_i,
  output logic         imemreq_rdy_o,
  input  logic [174:0] dmemreq_msg_i,
  input  logic         dmemreq_val_i,
  output logic         dmemreq_rdy_o,
  output logic [174:0] memreq_msg_o,
  output logic         memreq_val_o,
  input  logic         memreq_rdy_i,
  input  logic [144:0] memresp_msg_i,
  input  logic         memresp_val_i,
  output logic         memresp_rdy_o,
  output logic [144:0] imemresp_msg_o,
  output logic         imemresp_val_o,
  input  logic         imemresp_rdy_i,
  output logic [144:0] dmemresp_msg_o,
  output logic         dmemresp_val_o,
  input  logic         dmemresp_rdy_i
);

  localparam int              c_pw    = $clog2(P_MAX_OUTSTANDING);
  localparam int              c_cw    = c_pw + 1;
  localparam logic [c_cw-1:0] c_depth = c_cw'(P_MAX_OUTSTANDING);
  localparam logic            c_src_i = 1'b0;
  localparam logic            c_src_d = 1'b1;

  logic [174:0]                 memreq_msg_q, memreq_msg_d;
  logic                         memreq_val_q, memreq_val_d;
  logic [P_MAX_OUTSTANDING-1:0] id_fifo_q, id_fifo_d;
  logic [c_pw-1:0]              wr_ptr_q, wr_ptr_d;
  logic [c_pw-1:0]              rd_ptr_q, rd_ptr_d;
  logic [c_cw-1:0]              count_q, count_d;
  logic                         prio_q, prio_d;

  logic w_slot_free, w_not_full, w_can_issue;
  logic w_grant_any, w_grant_src;
  logic w_push, w_pop, w_head, w_nonempty;

  assign memreq_msg_o   = memreq_msg_q;
  assign memreq_val_o   = memreq_val_q;
  // Responses pass through unmodified; only the valid/ready pair is steered.
  assign imemresp_msg_o = memresp_msg_i;
  assign dmemresp_msg_o = memresp_msg_i;

  always_comb begin
    w_slot_free = ~memreq_val_q | memreq_rdy_i;
    // Fullness is judged on the registered count only, so a response popping
    // this cycle never opens the request side combinationally.
    w_not_full  = (count_q != c_depth);
    w_can_issue = w_slot_free & w_not_full & rst_n;

    w_grant_any = 1'b0;
    w_grant_src = c_src_i;
    if (imemreq_val_i && (!dmemreq_val_i || prio_q == c_src_i)) begin
      w_grant_any = 1'b1;
      w_grant_src = c_src_i;
    end else if (dmemreq_val_i) begin
      w_grant_any = 1'b1;
      w_grant_src = c_src_d;
    end

    imemreq_rdy_o = w_grant_any & (w_grant_src == c_src_i) & w_can_issue;
    dmemreq_rdy_o = w_grant_any & (w_grant_src == c_src_d) & w_can_issue;
    w_push        = w_grant_any & w_can_issue;

    w_head         = id_fifo_q[rd_ptr_q];
    w_nonempty     = (count_q != '0);
    imemresp_val_o = w_nonempty & (w_head == c_src_i) & memresp_val_i;
    dmemresp_val_o = w_nonempty & (w_head == c_src_d) & memresp_val_i;
    memresp_rdy_o  = w_nonempty & ((w_head == c_src_d) ? dmemresp_rdy_i : imemresp_rdy_i);
    w_pop          = memresp_val_i & memresp_rdy_o;

    memreq_msg_d = memreq_msg_q;
    memreq_val_d = memreq_val_q;
    id_fifo_d    = id_fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    prio_d       = prio_q;

    if (w_push) begin
      memreq_msg_d          = (w_grant_src == c_src_d) ? dmemreq_msg_i : imemreq_msg_i;
      memreq_val_d          = 1'b1;
      id_fifo_d[wr_ptr_q]   = w_grant_src;
      wr_ptr_d              = wr_ptr_q + c_pw'(1);
      prio_d                = ~w_grant_src;
    end else if (memreq_rdy_i) begin
      memreq_val_d = 1'b0;
    end

    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + c_pw'(1);
    end

    count_d = count_q + c_cw'(w_push) - c_cw'(w_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memreq_msg_q <= '0;
      memreq_val_q <= 1'b0;
      id_fifo_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      prio_q       <= c_src_i;
    end else begin
      memreq_msg_q <= memreq_msg_d;
      memreq_val_q <= memreq_val_d;
      id_fifo_q    <= id_fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      prio_q       <= prio_d;
    end
  end

endmodule
`default_nettype wire
